// File: rtl/nn_host_driver.sv
// Host-side initiator for an HLS neural-network core: issues upstream samples under a credit
// limit, captures every core result into a first-word-fall-through FIFO, and runs counted batches.
module nn_host_driver #(
  parameter int NUM_DATA_INPUTS   = 1,
  parameter int INPUT_DATA_WIDTH  = 16,
  parameter int NUM_DATA_OUTPUTS  = 2,
  parameter int OUTPUT_DATA_WIDTH = 33,
  parameter int MAX_OUTSTANDING   = 4,
  parameter int RESULT_FIFO_DEPTH = 8,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         cmd_start,
  input  logic [COUNT_WIDTH-1:0]       cmd_num_samples,
  output logic                         busy,
  output logic                         done,
  output logic                         err_overflow,
  output logic                         err_unexpected,
  input  logic                         src_valid,
  input  logic [INPUT_DATA_WIDTH-1:0]  src_data [NUM_DATA_INPUTS],
  output logic                         src_ready,
  output logic                         nn_ap_start,
  output logic                         nn_data_in_valid,
  output logic [INPUT_DATA_WIDTH-1:0]  nn_data_in [NUM_DATA_INPUTS],
  input  logic                         nn_ap_ready,
  input  logic                         nn_ap_idle,
  input  logic                         nn_data_out_valid,
  input  logic [OUTPUT_DATA_WIDTH-1:0] nn_data_out [NUM_DATA_OUTPUTS],
  output logic                         res_valid,
  output logic [OUTPUT_DATA_WIDTH-1:0] res_data [NUM_DATA_OUTPUTS],
  input  logic                         res_ready,
  output logic [1:0]                   dbg_state
);

  localparam int PW  = $clog2(RESULT_FIFO_DEPTH);
  localparam int OCW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] num_q, num_d;
  logic [COUNT_WIDTH-1:0] issued_q, issued_d;
  logic [COUNT_WIDTH-1:0] received_q, received_d;
  logic [OCW-1:0]         outstanding_q, outstanding_d;
  logic [OCW-1:0]         fifo_count_q, fifo_count_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic                   err_overflow_q, err_overflow_d;
  logic                   err_unexpected_q, err_unexpected_d;

  logic [NUM_DATA_OUTPUTS-1:0][OUTPUT_DATA_WIDTH-1:0] mem_q [RESULT_FIFO_DEPTH];
  logic [NUM_DATA_OUTPUTS-1:0][OUTPUT_DATA_WIDTH-1:0] push_word;

  logic           credit_ok, fire, push, pop, fifo_full;
  logic [OCW:0]   credit_sum;
  logic           unused_idle;

  assign unused_idle = nn_ap_idle;
  assign nn_data_in  = src_data;
  assign dbg_state   = state_q;

  // Handshakes: a transfer happens on a cycle where both valid and ready are high; valid never
  // waits on ready. src_ready and the core fire are the same event.
  always_comb begin
    credit_sum       = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
    credit_ok        = (outstanding_q < OCW'(MAX_OUTSTANDING)) &&
                       (credit_sum < (OCW+1)'(RESULT_FIFO_DEPTH));
    nn_ap_start      = (state_q == S_RUN);
    nn_data_in_valid = nn_ap_start && (issued_q < num_q) && src_valid && credit_ok;
    fire             = nn_data_in_valid && nn_ap_ready;
    src_ready        = fire;
    res_valid        = (fifo_count_q != '0);
    pop              = res_valid && res_ready;
    fifo_full        = (fifo_count_q == OCW'(RESULT_FIFO_DEPTH));
    push             = nn_data_out_valid && (!fifo_full || pop);
    busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
    done             = (state_q == S_DONE);
    err_overflow     = err_overflow_q;
    err_unexpected   = err_unexpected_q;
    for (int i = 0; i < NUM_DATA_OUTPUTS; i++) begin
      push_word[i] = nn_data_out[i];
      res_data[i]  = res_valid ? mem_q[rd_ptr_q][i] : '0;
    end
  end

  always_comb begin
    state_d          = state_q;
    num_d            = num_q;
    issued_d         = issued_q;
    received_d       = received_q;
    err_overflow_d   = err_overflow_q;
    err_unexpected_d = err_unexpected_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          if (cmd_num_samples != '0) begin
            state_d          = S_RUN;
            num_d            = cmd_num_samples;
            issued_d         = '0;
            received_d       = '0;
            err_overflow_d   = 1'b0;
            err_unexpected_d = 1'b0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN:   if (issued_q == num_q && !fire) state_d = S_DRAIN;
      S_DRAIN: if (received_q == num_q) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    // Result capture counts in every state, so it is applied after any batch-start clear.
    if (fire) issued_d = issued_d + COUNT_WIDTH'(1);
    if (nn_data_out_valid) received_d = received_d + COUNT_WIDTH'(1);
    if (nn_data_out_valid && !push) err_overflow_d = 1'b1;
    if (nn_data_out_valid && outstanding_q == '0) err_unexpected_d = 1'b1;
  end

  always_comb begin
    outstanding_d = outstanding_q;
    if (fire && !nn_data_out_valid) begin
      outstanding_d = outstanding_q + OCW'(1);
    end else if (!fire && nn_data_out_valid && outstanding_q != '0) begin
      outstanding_d = outstanding_q - OCW'(1);
    end
    wr_ptr_d     = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    fifo_count_d = fifo_count_q + OCW'(push) - OCW'(pop);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q          <= S_IDLE;
      num_q            <= '0;
      issued_q         <= '0;
      received_q       <= '0;
      outstanding_q    <= '0;
      fifo_count_q     <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      err_overflow_q   <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      num_q            <= num_d;
      issued_q         <= issued_d;
      received_q       <= received_d;
      outstanding_q    <= outstanding_d;
      fifo_count_q     <= fifo_count_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      err_overflow_q   <= err_overflow_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  // Storage needs no reset: res_data is masked while the FIFO is empty.
  always_ff @(posedge ap_clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

endmodule

// File: tb/tb_nn_host_driver.sv
// Bench for nn_host_driver: a fixed-latency core model, a random upstream source and a
// result scoreboard fed from the samples the bench itself sends.
module tb_nn_host_driver;

  localparam int NI = 1, IW = 16, NO = 2, OW = 33, MAXO = 4, DEPTH = 8, CNTW = 16;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n = 1'b0;
  logic          cmd_start = 1'b0;
  logic [CNTW-1:0] cmd_num_samples = '0;
  logic          busy, done, err_overflow, err_unexpected;
  logic          src_valid = 1'b0;
  logic [IW-1:0] src_data [NI];
  logic          src_ready, nn_ap_start, nn_data_in_valid;
  logic [IW-1:0] nn_data_in [NI];
  logic          nn_ap_ready = 1'b0;
  logic          nn_ap_idle = 1'b1;
  logic          nn_data_out_valid = 1'b0;
  logic [OW-1:0] nn_data_out [NO];
  logic          res_valid;
  logic [OW-1:0] res_data [NO];
  logic          res_ready = 1'b0;
  logic [1:0]    dbg_state;

  nn_host_driver dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .cmd_start(cmd_start), .cmd_num_samples(cmd_num_samples),
    .busy(busy), .done(done), .err_overflow(err_overflow), .err_unexpected(err_unexpected),
    .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
    .nn_ap_start(nn_ap_start), .nn_data_in_valid(nn_data_in_valid), .nn_data_in(nn_data_in),
    .nn_ap_ready(nn_ap_ready), .nn_ap_idle(nn_ap_idle), .nn_data_out_valid(nn_data_out_valid),
    .nn_data_out(nn_data_out), .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- model state ----------------
  typedef struct { int due; logic [2*OW-1:0] w; } pend_t;
  pend_t           pend_q[$];
  logic [2*OW-1:0] exp_q[$];
  logic [IW-1:0]   src_q[$];
  int              fire_cyc[$];
  int cyc = 0, lat = 2, valid_pct = 100, ready_pct = 100;
  int fifo_m = 0, fires = 0, captured = 0, done_cnt = 0, max_out = 0;
  int n_checks = 0, n_fail = 0;
  bit last_fire = 0;

  function automatic logic [2*OW-1:0] core_fn(input logic [IW-1:0] x);
    logic [OW-1:0] o0, o1;
    o0 = OW'(x) * 33'd5 + 33'd1;
    o1 = {x, 17'h15A5A};
    return {o1, o0};
  endfunction

  // Core model: results leave exactly lat cycles after their fire.
  pend_t core_p;
  always @(posedge ap_clk) begin
    #1;
    cyc++;
    nn_ap_ready       = ($urandom_range(99) < ready_pct);
    nn_data_out_valid = 1'b0;
    nn_data_out[0]    = OW'($urandom);
    nn_data_out[1]    = OW'($urandom);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      core_p = pend_q.pop_front();
      nn_data_out_valid = 1'b1;
      nn_data_out[0] = core_p.w[OW-1:0];
      nn_data_out[1] = core_p.w[2*OW-1:OW];
    end
  end

  // Upstream source: holds valid and data until accepted.
  always @(posedge ap_clk) begin
    #1;
    if (ap_rst_n && src_q.size() > 0) begin
      if (!(src_valid && !last_fire)) src_valid = ($urandom_range(99) < valid_pct);
      src_data[0] = src_q[0];
    end else begin
      src_valid   = 1'b0;
      src_data[0] = IW'($urandom);
    end
  end

  // Monitor and scoreboard.
  logic mon_fire, mon_push, mon_pop;
  int   out_m;
  logic [2*OW-1:0] mon_got, mon_exp;
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      mon_fire = nn_ap_start && nn_data_in_valid && nn_ap_ready;
      out_m = pend_q.size() + (nn_data_out_valid ? 1 : 0);
      n_checks++;
      if (res_valid !== (fifo_m != 0)) begin
        n_fail++;
        $display("FAIL fwft_valid: res_valid=%0b required %0b at cycle %0d", res_valid, fifo_m != 0, cyc);
      end
      if (mon_fire) begin
        n_checks++;
        if (out_m >= MAXO || out_m + fifo_m >= DEPTH) begin
          n_fail++;
          $display("FAIL credit: fired with outstanding=%0d fifo=%0d, required below %0d and %0d total",
                   out_m, fifo_m, MAXO, DEPTH);
        end
        n_checks++;
        if (src_q.size() == 0 || nn_data_in[0] !== src_q[0]) begin
          n_fail++;
          $display("FAIL issue_data: core got %h, required head of source queue (size %0d)",
                   nn_data_in[0], src_q.size());
        end
        if (out_m + 1 > max_out) max_out = out_m + 1;
        pend_q.push_back('{cyc + lat, core_fn(nn_data_in[0])});
        if (src_q.size() > 0) src_q.delete(0);
        fires++;
        fire_cyc.push_back(cyc);
      end
      last_fire = mon_fire;
      mon_pop  = res_ready && (fifo_m != 0);
      mon_push = nn_data_out_valid && (fifo_m < DEPTH || mon_pop);
      if (nn_data_out_valid) captured++;
      if (mon_pop) begin
        n_checks++;
        mon_got = {res_data[1], res_data[0]};
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL result_extra: popped %h, required nothing", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL result_data: got %h required %h", mon_got, mon_exp);
          end
        end
      end
      fifo_m = fifo_m + (mon_push ? 1 : 0) - (mon_pop ? 1 : 0);
      if (done) done_cnt++;
    end else begin
      last_fire = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_samples(input int n);
    logic [IW-1:0] s;
    for (int i = 0; i < n; i++) begin
      s = IW'($urandom);
      src_q.push_back(s);
      exp_q.push_back(core_fn(s));
    end
  endtask

  task automatic pulse_start(input int n);
    @(posedge ap_clk); #2;
    cmd_start = 1'b1;
    cmd_num_samples = CNTW'(n);
    @(posedge ap_clk); #2;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin @(posedge ap_clk); k++; end
    n_checks++;
    if (done_cnt == d0) begin
      n_fail++;
      $display("FAIL %s_done_timeout: no done within %0d cycles", name, budget);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin @(posedge ap_clk); k++; end
    repeat (2) @(posedge ap_clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d results missing, required 0", name, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [7:0] obs;
    obs = {busy, done, err_overflow, err_unexpected, src_ready, nn_ap_start, nn_data_in_valid, res_valid};
    n_checks++;
    if (obs !== 8'h00) begin
      n_fail++;
      $display("FAIL %s_outputs: flags=%b required 00000000", name, obs);
    end
    n_checks++;
    if ({res_data[1], res_data[0]} !== '0) begin
      n_fail++;
      $display("FAIL %s_res_data: got %h required 0", name, {res_data[1], res_data[0]});
    end
    n_checks++;
    if (nn_data_in[0] !== src_data[0]) begin
      n_fail++;
      $display("FAIL %s_data_in: got %h required %h", name, nn_data_in[0], src_data[0]);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    check_reset_outputs("reset");
    @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);
    check_reset_outputs("after_reset");
  endtask

  task automatic test_basic();
    int idx = fire_cyc.size();
    int f0 = fires;
    int d0 = done_cnt;
    lat = 2; valid_pct = 100; ready_pct = 100; res_ready = 1'b1;
    load_samples(3);
    pulse_start(3);
    wait_done(60, "basic");
    wait_drain(40, "basic");
    n_checks++;
    if (fires - f0 != 3 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_counts: fires=%0d dones=%0d required 3 and 1", fires - f0, done_cnt - d0);
    end
    n_checks++;
    if (fire_cyc.size() < idx + 3 || fire_cyc[idx+1] != fire_cyc[idx] + 1 || fire_cyc[idx+2] != fire_cyc[idx] + 2) begin
      n_fail++;
      $display("FAIL basic_back_to_back: fires not on 3 consecutive cycles (%0d recorded)", fire_cyc.size() - idx);
    end
    n_checks++;
    if ({err_overflow, err_unexpected} !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_errors: got %b required 00", {err_overflow, err_unexpected});
    end
  endtask

  task automatic test_credit();
    int idx = fire_cyc.size();
    lat = 10; max_out = 0; res_ready = 1'b1;
    load_samples(8);
    pulse_start(8);
    wait_done(200, "credit");
    wait_drain(40, "credit");
    n_checks++;
    if (max_out != MAXO) begin
      n_fail++;
      $display("FAIL credit_max_outstanding: got %0d required %0d", max_out, MAXO);
    end
    n_checks++;
    if (fire_cyc.size() < idx + 5 || fire_cyc[idx+3] != fire_cyc[idx] + 3 || fire_cyc[idx+4] != fire_cyc[idx] + lat + 1) begin
      n_fail++;
      $display("FAIL credit_stall: fifth fire not at first fire + %0d", lat + 1);
    end
  endtask

  task automatic test_backpressure();
    int f0 = fires;
    lat = 2; res_ready = 1'b0;
    load_samples(12);
    pulse_start(12);
    repeat (40) @(posedge ap_clk);
    @(negedge ap_clk);
    n_checks++;
    if (fires - f0 != DEPTH || fifo_m != DEPTH || res_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_stall: fires=%0d fifo=%0d res_valid=%b busy=%b required %0d %0d 1 1",
               fires - f0, fifo_m, res_valid, busy, DEPTH, DEPTH);
    end
    @(posedge ap_clk); #2;
    res_ready = 1'b1;
    wait_done(200, "bp");
    wait_drain(40, "bp");
    n_checks++;
    if (fires - f0 != 12 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_final: fires=%0d err_overflow=%b required 12 0", fires - f0, err_overflow);
    end
  endtask

  task automatic test_back_to_back();
    int idx = fire_cyc.size();
    logic [IW-1:0] x;
    bit ok;
    lat = 1; res_ready = 1'b1;
    load_samples(6);
    pulse_start(6);
    wait_done(60, "b2b");
    wait_drain(40, "b2b");
    ok = (fire_cyc.size() == idx + 6);
    for (int i = 1; i < 6 && ok; i++) ok = (fire_cyc[idx+i] == fire_cyc[idx] + i);
    n_checks++;
    if (!ok || err_unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_overlap: consecutive=%0b err_unexpected=%b required 1 0", ok, err_unexpected);
    end
    // A result with nothing outstanding, while idle.
    @(posedge ap_clk); #2;
    x = IW'($urandom);
    exp_q.push_back(core_fn(x));
    pend_q.push_back('{cyc + 2, core_fn(x)});
    wait_drain(10, "unexpected");
    @(negedge ap_clk);
    n_checks++;
    if ({err_unexpected, err_overflow} !== 2'b10) begin
      n_fail++;
      $display("FAIL unexpected_flag: got %b required 10", {err_unexpected, err_overflow});
    end
    // Random traffic; the new batch clears the sticky flag.
    lat = 3; valid_pct = 60; ready_pct = 70;
    load_samples(10);
    pulse_start(10);
    @(negedge ap_clk);
    n_checks++;
    if (err_unexpected !== 1'b0) begin
      n_fail++;
      $display("FAIL unexpected_clear: got %b required 0", err_unexpected);
    end
    wait_done(300, "random");
    wait_drain(40, "random");
    valid_pct = 100; ready_pct = 100;
  endtask

  task automatic test_zero_and_busy();
    int f0 = fires;
    lat = 2; res_ready = 1'b1;
    pulse_start(0);
    @(negedge ap_clk);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b required 1 0", done, busy);
    end
    @(negedge ap_clk);
    n_checks++;
    if (done !== 1'b0 || fires != f0) begin
      n_fail++;
      $display("FAIL zero_pulse: done=%b fires=%0d required 0 0", done, fires - f0);
    end
    pulse_start(5);
    pulse_start(2);
    @(negedge ap_clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_flag: got %b required 1", busy);
    end
    load_samples(5);
    wait_done(100, "busy_ignore");
    wait_drain(40, "busy_ignore");
    n_checks++;
    if (fires - f0 != 5) begin
      n_fail++;
      $display("FAIL busy_ignore: fires=%0d required 5", fires - f0);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int d0, f0;
    lat = 6; res_ready = 1'b0;
    load_samples(8);
    pulse_start(8);
    while (fifo_m < 3 && k < 100) begin @(posedge ap_clk); k++; end
    n_checks++;
    if (fifo_m < 3 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_setup: fifo=%0d busy=%b required 3 1", fifo_m, busy);
    end
    @(posedge ap_clk); #2;
    d0 = done_cnt;
    ap_rst_n = 1'b0;
    pend_q.delete(); exp_q.delete(); src_q.delete(); fifo_m = 0;
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge ap_clk);
    #2;
    ap_rst_n = 1'b1;
    res_ready = 1'b1; lat = 2;
    f0 = fires;
    load_samples(1);
    pulse_start(1);
    wait_done(40, "post_reset");
    wait_drain(20, "post_reset");
    n_checks++;
    if (fires - f0 != 1 || done_cnt - d0 != 1 || {err_overflow, err_unexpected} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset: fires=%0d dones=%0d errs=%b required 1 1 00",
               fires - f0, done_cnt - d0, {err_overflow, err_unexpected});
    end
  endtask

  initial begin
    src_data[0] = '0;
    nn_data_out[0] = '0;
    nn_data_out[1] = '0;
    test_reset();
    test_basic();
    test_credit();
    test_backpressure();
    test_back_to_back();
    test_zero_and_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
